// File: rtl/mic_pkg.sv
// Shared types and helpers for the MIC-2 instruction fetch unit.
package mic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } ifu_state_t;

    localparam int WORD_BYTES = 4;

    // Byte idx of a big-endian word: idx 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mic_byte_queue.sv
// Circular byte queue for the fetch unit. Pushes the tail bytes of a word
// (starting at a skip offset) and pops 0/1/2 bytes from the head. The head
// pointer wraps with an explicit compare, so depth need not be a power of two.
module mic_byte_queue
    import mic_pkg::*;
#(
    parameter  int QUEUE_BYTES = 8,
    localparam int CNT_W       = $clog2(QUEUE_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [31:0]      push_word_i,
    input  logic [1:0]       push_skip_i,
    input  logic [1:0]       pop_n_i,
    output logic [7:0]       head0_o,
    output logic [7:0]       head1_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(QUEUE_BYTES);
    localparam int SUM_W = PTR_W + 2;

    logic [7:0]       buf_q [QUEUE_BYTES];
    logic [7:0]       buf_d [QUEUE_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] tail_s;
    logic [2:0]       push_n_s;

    // Reduce a value below 2*QUEUE_BYTES into the pointer range.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [SUM_W-1:0] x);
        logic [PTR_W-1:0] r;
        if (x >= SUM_W'(QUEUE_BYTES)) begin
            r = PTR_W'(x - SUM_W'(QUEUE_BYTES));
        end else begin
            r = PTR_W'(x);
        end
        return r;
    endfunction

    assign push_n_s = 3'(WORD_BYTES) - {1'b0, push_skip_i};
    assign tail_s   = wrap_idx(SUM_W'(head_q) + SUM_W'(count_q));

    // Next-state of storage, head and count; each slot checks its offset from the tail.
    always_comb begin
        buf_d   = buf_q;
        head_d  = head_q;
        count_d = count_q;
        for (int j = 0; j < QUEUE_BYTES; j++) begin
            if (push_i && !flush_i &&
                (SUM_W'(wrap_idx(SUM_W'(j) + SUM_W'(QUEUE_BYTES) - SUM_W'(tail_s))) < SUM_W'(push_n_s))) begin
                buf_d[j] = word_byte(push_word_i, push_skip_i +
                           2'(wrap_idx(SUM_W'(j) + SUM_W'(QUEUE_BYTES) - SUM_W'(tail_s))));
            end else begin
                buf_d[j] = buf_q[j];
            end
        end
        if (flush_i) begin
            head_d  = '0;
            count_d = '0;
        end else begin
            head_d  = wrap_idx(SUM_W'(head_q) + SUM_W'(pop_n_i));
            count_d = count_q - CNT_W'(pop_n_i) + (push_i ? CNT_W'(push_n_s) : CNT_W'(1'b0));
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < QUEUE_BYTES; j++) begin
                buf_q[j] <= 8'h00;
            end
            head_q  <= '0;
            count_q <= '0;
        end else begin
            buf_q   <= buf_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    assign head0_o = buf_q[head_q];
    assign head1_o = buf_q[wrap_idx(SUM_W'(head_q) + SUM_W'(1'b1))];
    assign count_o = count_q;

endmodule

// File: rtl/mic_ifu.sv
// MIC-2 instruction fetch unit: fetch FSM, PC tracking and the single
// outstanding word-read handshake feeding the MBR byte queue.
module mic_ifu
    import mic_pkg::*;
#(
    parameter int QUEUE_BYTES = 8,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              mbr1_consume,
    input  logic              mbr2_consume,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        mbr1,
    output logic              mbr1_valid,
    output logic [15:0]       mbr2,
    output logic              mbr2_valid,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int CNT_W = $clog2(QUEUE_BYTES + 1);
    localparam int CW1   = CNT_W + 1;
    localparam int FA_W  = ADDR_W - 2;

    ifu_state_t        state_q, state_d;
    logic [FA_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [FA_W-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        skip_q, skip_d;
    logic [CNT_W-1:0]  count_s;
    logic [7:0]        head0_s, head1_s;
    logic              ack_s, push_s, new_req_s, room_s, room_after_s;
    logic [1:0]        pop_s;
    logic [2:0]        push_n_s;

    // An ack only counts while a request is actually outstanding.
    assign ack_s        = mem_ack & mem_req_q;
    assign push_n_s     = 3'(WORD_BYTES) - {1'b0, skip_q};
    // Free-space checks use the count before any pop in this cycle.
    assign room_s       = ({1'b0, count_s} + CW1'(WORD_BYTES)) <= CW1'(QUEUE_BYTES);
    assign room_after_s = ({1'b0, count_s} + CW1'(push_n_s) + CW1'(WORD_BYTES)) <= CW1'(QUEUE_BYTES);

    // Consume arbitration: load wins, two-byte consume beats one-byte, oversize is dropped.
    always_comb begin
        pop_s = 2'd0;
        if (pc_load) begin
            pop_s = 2'd0;
        end else if (mbr2_consume) begin
            pop_s = (count_s >= CNT_W'(2'd2)) ? 2'd2 : 2'd0;
        end else if (mbr1_consume) begin
            pop_s = (count_s >= CNT_W'(1'b1)) ? 2'd1 : 2'd0;
        end else begin
            pop_s = 2'd0;
        end
    end

    // Fetch FSM next state, push decision and request address capture.
    always_comb begin
        state_d   = state_q;
        push_s    = 1'b0;
        new_req_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!pc_load && room_s) begin
                    state_d   = REQ;
                    new_req_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (pc_load) begin
                    state_d = ack_s ? IDLE : DISCARD;
                end else if (ack_s) begin
                    push_s = 1'b1;
                    if (room_after_s) begin
                        state_d   = REQ;
                        new_req_s = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DISCARD: begin
                if (ack_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fetch_addr_d = pc_load ? pc_in[ADDR_W-1:2] :
                          (push_s ? fetch_addr_q + FA_W'(1'b1) : fetch_addr_q);
    assign skip_d       = pc_load ? pc_in[1:0] : (push_s ? 2'b00 : skip_q);
    assign pc_d         = pc_load ? pc_in : pc_q + ADDR_W'(pop_s);
    assign mem_addr_d   = new_req_s ? fetch_addr_d : mem_addr_q;
    assign mem_req_d    = (state_d != IDLE);

    // Control, PC and handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            pc_q         <= '0;
            skip_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            pc_q         <= pc_d;
            skip_q       <= skip_d;
        end
    end

    mic_byte_queue #(
        .QUEUE_BYTES (QUEUE_BYTES)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (pc_load),
        .push_i      (push_s),
        .push_word_i (mem_rdata),
        .push_skip_i (skip_q),
        .pop_n_i     (pop_s),
        .head0_o     (head0_s),
        .head1_o     (head1_s),
        .count_o     (count_s)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign pc_out     = pc_q;
    assign mbr1_valid = (count_s >= CNT_W'(1'b1));
    assign mbr2_valid = (count_s >= CNT_W'(2'd2));
    assign mbr1       = mbr1_valid ? head0_s : 8'h00;
    assign mbr2       = mbr2_valid ? {head0_s, head1_s} : 16'h0000;

endmodule

// File: tb/tb_mic_ifu.sv
// Scoreboard bench for mic_ifu: a byte-stream reference model plus a memory
// responder produce expected MBR/PC state each cycle; a monitor compares.
module tb_mic_ifu;

    localparam int QB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        mbr1_consume = 1'b0;
    logic        mbr2_consume = 1'b0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [7:0]  mbr1;
    logic        mbr1_valid;
    logic [15:0] mbr2;
    logic        mbr2_valid;
    logic [31:0] pc_out;

    mic_ifu #(.QUEUE_BYTES(QB), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
        .mbr1_consume(mbr1_consume), .mbr2_consume(mbr2_consume),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mbr1(mbr1), .mbr1_valid(mbr1_valid), .mbr2(mbr2), .mbr2_valid(mbr2_valid),
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v1;
        logic [7:0]  b1;
        logic        v2;
        logic [15:0] b2;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mq[$];          // model of bytes available from pc upward
    logic [31:0] m_pc;
    logic [29:0] m_fetch;
    logic [1:0]  m_skip;
    bit          out, stale, mon_en, stray_en;
    logic [29:0] req_addr;
    int          wait_n, lat;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] memword(input logic [29:0] a);
        if (a == 30'd0) return 32'h1059_A700;
        else if (a == 30'h41) return 32'hAABB_CCDD;
        else return {a[7:0] ^ 8'h5A, a[15:8], ~a[7:0], a[7:0] + 8'h33};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: memory responder, inputs, then the model update at the edge.
    task automatic step(input logic pl, input logic [31:0] pin, input logic c1, input logic c2);
        logic        real_ack;
        logic [31:0] w;
        int          n;
        exp_t        e;
        if (mem_req && !out) begin
            out = 1'b1; stale = 1'b0; req_addr = mem_addr;
            wait_n = (lat < 0) ? $urandom_range(0, 3) : lat;
            chk("req_addr", 32'(mem_addr), 32'(m_fetch));
            chk("req_room", 32'(mq.size() <= QB - 4), 32'd1);
        end
        real_ack = 1'b0;
        if (out && wait_n == 0) begin
            real_ack = 1'b1; mem_ack = 1'b1; mem_rdata = memword(req_addr);
        end else begin
            if (out) wait_n--;
            mem_ack = !out && stray_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
        pc_load = pl; pc_in = pin; mbr1_consume = c1; mbr2_consume = c2;
        @(posedge clk);
        if (pl) begin
            mq.delete(); m_pc = pin; m_fetch = pin[31:2]; m_skip = pin[1:0];
            if (real_ack) out = 1'b0;
            else if (out) stale = 1'b1;
        end else begin
            n = 0;
            if (c2) n = (mq.size() >= 2) ? 2 : 0;
            else if (c1) n = (mq.size() >= 1) ? 1 : 0;
            for (int k = 0; k < n; k++) void'(mq.pop_front());
            m_pc = m_pc + 32'(n);
            if (real_ack) begin
                if (!stale) begin
                    w = memword(req_addr);
                    for (int b = int'(m_skip); b < 4; b++) mq.push_back(w[8*(3-b) +: 8]);
                    m_fetch = m_fetch + 30'd1;
                    m_skip = 2'd0;
                end
                out = 1'b0;
            end
        end
        e.v1 = (mq.size() >= 1);
        e.b1 = e.v1 ? mq[0] : 8'h00;
        e.v2 = (mq.size() >= 2);
        e.b2 = e.v2 ? {mq[0], mq[1]} : 16'h0000;
        e.pc = m_pc;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: pop the expected state for this cycle and compare away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mbr1_valid", 32'(mbr1_valid), 32'(e.v1));
            chk("mbr1", 32'(mbr1), 32'(e.b1));
            chk("mbr2_valid", 32'(mbr2_valid), 32'(e.v2));
            chk("mbr2", 32'(mbr2), 32'(e.b2));
            chk("pc_out", pc_out, e.pc);
        end
    end

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2:       return 32'($urandom_range(0, 255));
            default: return 32'h0000_0106;
        endcase
    endfunction

    initial begin
        mon_en = 1'b0; stray_en = 1'b0; out = 1'b0; stale = 1'b0; lat = 0; wait_n = 0;
        mq.delete(); m_pc = 32'h0; m_fetch = 30'h0; m_skip = 2'd0; req_addr = 30'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mbr1", 32'(mbr1), 32'd0);
        chk("rst_mbr1_valid", 32'(mbr1_valid), 32'd0);
        chk("rst_mbr2", 32'(mbr2), 32'd0);
        chk("rst_mbr2_valid", 32'(mbr2_valid), 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Word 0 with 1-cycle ack, then consume mbr1, mbr2, mbr1.
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);

        // Load to 0x106: word 0x41, two leading bytes skipped.
        step(1'b1, 32'h0000_0106, 1'b0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);

        // Load while a slow request is outstanding: the old word is discarded.
        lat = 3;
        step(1'b1, 32'h0000_1000, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_2000, 1'b0, 1'b0);
        repeat (12) step(1'b0, 32'h0, 1'b0, 1'b0);

        // One byte queued: oversize consumes are ignored.
        step(1'b1, 32'h0000_0307, 1'b0, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill the queue with no consumes: no further requests.
        lat = -1;
        step(1'b1, 32'h0000_0200, 1'b0, 1'b0);
        repeat (30) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_no_req", 32'(mem_req), 32'd0);

        // Randomized traffic with stray acks and occasional loads.
        stray_en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) step(1'b1, rand_pc(), 1'b0, 1'b0);
            else step(1'b0, 32'h0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a request.
        stray_en = 1'b0; lat = 3;
        step(1'b1, 32'h0000_0400, 1'b0, 1'b0);
        for (int i = 0; i < 10 && !mem_req; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_mbr1_valid", 32'(mbr1_valid), 32'd0);
        chk("mid_rst_mbr2", 32'(mbr2), 32'd0);
        chk("mid_rst_pc_out", pc_out, 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        pc_load = 1'b0; mbr1_consume = 1'b0; mbr2_consume = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", 32'(mem_addr), 32'd0);
        chk("post_rst_stray_ack", 32'(mbr1_valid), 32'd0);
        chk("post_rst_pc", pc_out, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
